// File: rtl/wash_if.sv
// wash_if: sequencer command/status and timer handshake bundle
interface wash_if;
  logic start;
  logic abort;
  logic timer_irq;
  logic [7:0] timer_set;
  logic timer_load;
  logic [2:0] phase;
  logic valve;
  logic motor;
  logic pump;
  logic busy;
  logic done;
  modport slave (input start, abort, timer_irq, output timer_set, timer_load, phase, valve, motor, pump, busy, done);
  modport master (output start, abort, timer_irq, input timer_set, timer_load, phase, valve, motor, pump, busy, done);
endinterface

// File: rtl/wash_sequencer.sv
// wash_sequencer: walks the wash program, loads phase durations into the timer and drives the actuators
module wash_sequencer #(
  parameter logic [7:0] FILL_T = 8'd6,
  parameter logic [7:0] WASH_T = 8'd20,
  parameter logic [7:0] DRAIN_T = 8'd4,
  parameter logic [7:0] RINSE_T = 8'd10,
  parameter logic [7:0] SPIN_T = 8'd12,
  parameter int unsigned RINSE_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  wash_if.slave w
);
  localparam logic [2:0] RC = 3'(RINSE_CYCLES);
  typedef enum logic [3:0] {S_IDLE, S_FILL0, S_WASH, S_DRAIN0, S_FILLR, S_RINSE, S_DRAINR, S_SPIN, S_DRAINA} state_t;
  typedef struct packed {
    state_t s;
    logic [2:0] c;
  } pos_t;
  state_t st_q;
  logic [2:0] cnt_q;
  logic aborted_q, aborted_d, load_q, load_d, done_q, done_d, go;
  logic [7:0] set_q, set_d;
  logic [2:0] ph;
  pos_t nx;
  function automatic logic [7:0] dur(state_t s);
    return s inside {S_FILL0, S_FILLR} ? FILL_T : s == S_WASH ? WASH_T :
           s inside {S_DRAIN0, S_DRAINR, S_DRAINA} ? DRAIN_T : s == S_RINSE ? RINSE_T :
           s == S_SPIN ? SPIN_T : 8'd0;
  endfunction
  function automatic pos_t succ(pos_t p);
    pos_t n = p;
    case (p.s)
      S_IDLE: n.s = S_FILL0;
      S_FILL0: n.s = S_WASH;
      S_WASH: n.s = S_DRAIN0;
      S_DRAIN0: n.s = p.c == RC ? S_SPIN : S_FILLR;
      S_FILLR: n.s = S_RINSE;
      S_RINSE: n.s = S_DRAINR;
      S_DRAINR: begin
        n.c = p.c + 3'd1;
        n.s = n.c == RC ? S_SPIN : S_FILLR;
      end
      default: n.s = S_IDLE;
    endcase
    return n;
  endfunction
  // zero-duration phases are hopped over in the same transition
  function automatic pos_t chain(pos_t p);
    pos_t n = p;
    for (int i = 0; i < 32; i++)
      if (n.s != S_IDLE && dur(n.s) == 8'd0) n = succ(n);
    return n;
  endfunction
  always_comb begin
    nx = pos_t'{st_q, cnt_q};
    go = 1'b0;
    aborted_d = aborted_q;
    if (st_q == S_IDLE) begin
      if (w.start) begin
        nx = chain(pos_t'{S_FILL0, 3'd0});
        aborted_d = 1'b0;
        go = 1'b1;
      end
    end else if (w.abort && st_q inside {S_FILL0, S_WASH, S_FILLR, S_RINSE}) begin
      nx.s = DRAIN_T != 8'd0 ? S_DRAINA : S_IDLE;
      aborted_d = 1'b1;
      go = 1'b1;
    end else if (w.timer_irq && !load_q) begin
      nx = aborted_q ? pos_t'{S_IDLE, cnt_q} : chain(succ(pos_t'{st_q, cnt_q}));
      go = 1'b1;
    end
    load_d = go && nx.s != S_IDLE;
    set_d = go ? dur(nx.s) : 8'd0;
    done_d = go && nx.s == S_IDLE && !aborted_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= S_IDLE;
      cnt_q <= 3'd0;
      aborted_q <= 1'b0;
      load_q <= 1'b0;
      set_q <= 8'd0;
      done_q <= 1'b0;
    end else begin
      st_q <= go ? nx.s : st_q;
      cnt_q <= go ? nx.c : cnt_q;
      aborted_q <= aborted_d;
      load_q <= load_d;
      set_q <= set_d;
      done_q <= done_d;
    end
  end
  always_comb ph = st_q inside {S_FILL0, S_FILLR} ? 3'd1 : st_q == S_WASH ? 3'd2 :
                   st_q inside {S_DRAIN0, S_DRAINR, S_DRAINA} ? 3'd3 : st_q == S_RINSE ? 3'd4 :
                   st_q == S_SPIN ? 3'd5 : 3'd0;
  assign w.phase = ph;
  assign w.valve = ph == 3'd1;
  assign w.motor = ph inside {3'd2, 3'd4, 3'd5};
  assign w.pump = ph inside {3'd3, 3'd5};
  assign w.busy = st_q != S_IDLE;
  assign w.timer_load = load_q;
  assign w.timer_set = set_q;
  assign w.done = done_q;
endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: scoreboard bench over three parameter sets with a behavioural program model
module tb_wash_sequencer;
  localparam int NI = 3;
  localparam int FT [NI] = '{3, 3, 0};
  localparam int WT [NI] = '{5, 0, 0};
  localparam int DT [NI] = '{2, 2, 0};
  localparam int RT [NI] = '{4, 4, 0};
  localparam int ST [NI] = '{6, 6, 0};
  localparam int RC [NI] = '{1, 0, 1};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_r [NI];
  logic start_r [NI];
  logic abort_r [NI];
  logic inj_irq [NI];
  logic inj_load [NI];
  logic load_w [NI];
  logic busy_w [NI];
  logic done_w [NI];
  logic [2:0] phase_w [NI];
  int vectors = 0;
  int errs = 0;
  int exp_q [NI][$];
  int mph [NI][$];
  int mdu [NI][$];

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : u
    wash_if w ();
    logic [7:0] tcnt = 8'd0;
    logic busy_q = 1'b0, done_q = 1'b0, irq_s = 1'b0, ld_s = 1'b0, busy_s = 1'b0;
    wash_sequencer #(.FILL_T(8'(FT[g])), .WASH_T(8'(WT[g])), .DRAIN_T(8'(DT[g])), .RINSE_T(8'(RT[g])),
                     .SPIN_T(8'(ST[g])), .RINSE_CYCLES(RC[g])) dut (.clk(clk), .rst(rst_r[g]), .w(w));
    assign w.start = start_r[g];
    assign w.abort = abort_r[g];
    assign w.timer_irq = tcnt == 8'd1 || inj_irq[g] || (inj_load[g] && w.timer_load);
    assign load_w[g] = w.timer_load;
    assign busy_w[g] = w.busy;
    assign done_w[g] = w.done;
    assign phase_w[g] = w.phase;
    always @(posedge clk) begin
      tcnt <= w.timer_load ? w.timer_set : tcnt != 8'd0 ? tcnt - 8'd1 : 8'd0;
      irq_s <= w.timer_irq;
      ld_s <= w.timer_load;
      busy_s <= w.busy;
    end
    always @(negedge clk) begin
      chk("valve", int'(w.valve), int'(w.phase == 3'd1));
      chk("motor", int'(w.motor), int'(w.phase inside {3'd2, 3'd4, 3'd5}));
      chk("pump", int'(w.pump), int'(w.phase inside {3'd3, 3'd5}));
      chk("busy", int'(w.busy), int'(w.phase != 3'd0));
      if (!w.timer_load) chk("set_nonload", int'(w.timer_set), 0);
      if (w.done) chk("done_width", int'(done_q), 0);
      if (irq_s && !ld_s && busy_s) chk("advance_lat", int'(w.timer_load || !w.busy), 1);
      if (w.timer_load) begin
        if (exp_q[g].size() == 0) chk("extra_load", int'(w.phase) * 256 + int'(w.timer_set), -1);
        else chk("load", int'(w.phase) * 256 + int'(w.timer_set), exp_q[g].pop_front());
      end
      if ((busy_q && !w.busy) || (!busy_q && !w.busy && w.done)) begin
        if (exp_q[g].size() == 0) chk("extra_end", 1000 + int'(w.done), -1);
        else chk("end_done", 1000 + int'(w.done), exp_q[g].pop_front());
      end
      busy_q <= w.busy;
      done_q <= w.done;
    end
  end

  task automatic add(int i, int p, int d);
    if (d > 0) begin
      mph[i].push_back(p);
      mdu[i].push_back(d);
    end
  endtask

  task automatic build(int i);
    mph[i].delete();
    mdu[i].delete();
    add(i, 1, FT[i]); add(i, 2, WT[i]); add(i, 3, DT[i]);
    for (int r = 0; r < RC[i]; r++) begin
      add(i, 1, FT[i]); add(i, 4, RT[i]); add(i, 3, DT[i]);
    end
    add(i, 5, ST[i]);
  endtask

  // kind: 0 plain run, 1 abort, 2 start while busy, 3 reset; applied d cycles into the k-th loaded phase
  task automatic run(int i, int kind, int k, int d);
    int n, t;
    bit eff;
    build(i);
    eff = kind == 1 && k < mph[i].size() && mph[i][k] inside {1, 2, 4};
    if (kind == 3 || eff) begin
      for (int j = 0; j <= k; j++) exp_q[i].push_back(mph[i][j] * 256 + mdu[i][j]);
      if (eff && DT[i] > 0) exp_q[i].push_back(3 * 256 + DT[i]);
      exp_q[i].push_back(1000);
    end else begin
      for (int j = 0; j < mph[i].size(); j++) exp_q[i].push_back(mph[i][j] * 256 + mdu[i][j]);
      exp_q[i].push_back(1001);
    end
    start_r[i] = 1'b1;
    @(negedge clk);
    start_r[i] = 1'b0;
    if (mph[i].size() > 0) chk("start_lat", int'(load_w[i]) * 8 + int'(phase_w[i]), 8 + mph[i][0]);
    else chk("skip_done", int'(done_w[i]) * 2 + int'(busy_w[i]), 2);
    if (kind != 0) begin
      n = load_w[i] ? 1 : 0;
      t = 0;
      while (n <= k && t < 500) begin
        @(negedge clk);
        t++;
        if (load_w[i]) n++;
      end
      if (t >= 500) chk("load_wait_timeout", t, 0);
      repeat (d) @(negedge clk);
      if (kind == 1) abort_r[i] = 1'b1;
      if (kind == 2) start_r[i] = 1'b1;
      if (kind == 3) rst_r[i] = 1'b1;
      @(negedge clk);
      abort_r[i] = 1'b0;
      start_r[i] = 1'b0;
      rst_r[i] = 1'b0;
      if (eff) chk("abort_lat", int'(load_w[i]) * 8 + int'(phase_w[i]), DT[i] > 0 ? 11 : 0);
      if (kind == 3) chk("reset_idle", int'(load_w[i]) * 8 + int'(phase_w[i]), 0);
    end
    t = 0;
    while (busy_w[i] && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("end_timeout", t, 0);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int i, kind, k, d;
    for (int j = 0; j < NI; j++) begin
      rst_r[j] = 1'b1; start_r[j] = 1'b0; abort_r[j] = 1'b0; inj_irq[j] = 1'b0; inj_load[j] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("rst_phase", int'(u[0].w.phase), 0);
    chk("rst_load_set", int'(u[0].w.timer_load) * 256 + int'(u[0].w.timer_set), 0);
    chk("rst_act", {u[0].w.valve, u[0].w.motor, u[0].w.pump, u[0].w.busy, u[0].w.done}, 0);
    for (int j = 0; j < NI; j++) rst_r[j] = 1'b0;
    @(negedge clk);
    run(0, 0, 0, 0);
    run(0, 1, 1, 2);
    inj_irq[0] = 1'b1;
    @(negedge clk);
    inj_irq[0] = 1'b0;
    @(negedge clk);
    chk("idle_irq", int'(phase_w[0]) * 2 + int'(busy_w[0]), 0);
    inj_load[0] = 1'b1;
    run(0, 0, 0, 0);
    inj_load[0] = 1'b0;
    run(0, 2, 4, 1);
    run(0, 1, 6, 3);
    run(0, 3, 4, 2);
    run(0, 0, 0, 0);
    run(1, 0, 0, 0);
    run(1, 1, 0, 1);
    run(2, 0, 0, 0);
    run(2, 0, 0, 0);
    repeat (40) begin
      i = int'($urandom_range(1, 0));
      build(i);
      kind = int'($urandom_range(3, 0));
      k = int'($urandom_range(mph[i].size() - 1, 0));
      d = int'($urandom_range(mdu[i][k], 0));
      run(i, kind, k, d);
    end
    for (int j = 0; j < NI; j++) chk("leftover", exp_q[j].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
